// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the fetch/decode front end
package mips_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;

    typedef enum logic [0:0] {
        IF_ISSUE = 1'b0,
        IF_WAIT  = 1'b1
    } if_state_e;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc_plus;
    } if_id_t;

    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction-memory read port (req/ready + rvalid)
interface if_stage_if #(
    parameter int ADDR_W = 32
) ();

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_skid_buf.sv
// rtl/if_skid_buf.sv - one-entry skid buffer with valid bit, reusable by later stages
module if_skid_buf
    import mips_pkg::*;
#(
    parameter type T = if_id_t
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic push_i,
    input  T     push_data_i,
    input  logic pop_i,
    output logic valid_o,
    output T     data_o
);

    logic valid_q, valid_d;
    T     data_q, data_d;

    // A push in the same cycle as a pop replaces the drained entry.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr_i) begin
            valid_d = 1'b0;
        end else if (push_i) begin
            valid_d = 1'b1;
            data_d  = push_data_i;
        end else if (pop_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage; IF_PERF_CNT_EN adds fetch/stall counters
module if_stage
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_INC   = 4
) (
    input  logic              clk,
    input  logic              rst,
    if_stage_if.master        imem,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [ADDR_W-1:0] pc_plus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    typedef struct packed {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] pc_plus;
    } entry_t;

    localparam logic [0:0]        ST_ISSUE = IF_ISSUE;
    localparam logic [0:0]        ST_WAIT  = IF_WAIT;
    localparam logic [ADDR_W-1:0] INC      = ADDR_W'(PC_INC);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              kill_q, kill_d;
    logic              ifid_v_q, ifid_v_d;
    entry_t            ifid_q, ifid_d;

    logic   skid_v, skid_push, skid_pop, skid_clr;
    entry_t skid_data;

    logic   fetch_fire, resp_live, consume, ifid_open;
    entry_t resp_entry;
    logic   unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Requests are gated by rst so nothing is issued while reset is held.
    assign imem.imem_req  = !rst && (state_q == ST_ISSUE) && !skid_v;
    assign imem.imem_addr = pc_q;

    assign fetch_fire = imem.imem_req && imem.imem_ready;
    assign resp_live  = (state_q == ST_WAIT) && imem.imem_rvalid && !kill_q;
    assign resp_entry = '{instr: imem.imem_rdata, pc_plus: fetch_pc_q + INC};
    assign consume    = ifid_v_q && !stall;
    assign ifid_open  = !ifid_v_q || consume;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        kill_d     = kill_q;
        ifid_v_d   = ifid_v_q;
        ifid_d     = ifid_q;
        skid_push  = 1'b0;
        skid_pop   = 1'b0;
        skid_clr   = 1'b0;

        case (state_q)
            ST_ISSUE: begin
                if (fetch_fire) begin
                    fetch_pc_d = pc_q;
                    pc_d       = pc_q + INC;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem.imem_rvalid) begin
                    kill_d  = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_ISSUE;
        endcase

        // Refill priority: skid entry first, then the live response.
        if (ifid_open) begin
            if (skid_v) begin
                ifid_d    = skid_data;
                ifid_v_d  = 1'b1;
                skid_pop  = 1'b1;
                skid_push = resp_live;
            end else if (resp_live) begin
                ifid_d   = resp_entry;
                ifid_v_d = 1'b1;
            end else begin
                ifid_v_d = 1'b0;
            end
        end else if (resp_live) begin
            skid_push = 1'b1;
        end

        // A request accepted alongside a redirect is still outstanding and must be killed.
        if (redirect_valid) begin
            pc_d      = {redirect_pc[ADDR_W-1:2], 2'b00};
            ifid_v_d  = 1'b0;
            skid_clr  = 1'b1;
            skid_push = 1'b0;
            skid_pop  = 1'b0;
            if (state_q == ST_WAIT) begin
                kill_d = !imem.imem_rvalid;
            end else begin
                kill_d = fetch_fire;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_ISSUE;
            pc_q           <= RESET_PC;
            fetch_pc_q     <= '0;
            kill_q         <= 1'b0;
            ifid_v_q       <= 1'b0;
            ifid_q.instr   <= NOP_INSTR;
            ifid_q.pc_plus <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            kill_q     <= kill_d;
            ifid_v_q   <= ifid_v_d;
            ifid_q     <= ifid_d;
        end
    end

    if_skid_buf #(
        .T (entry_t)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (skid_clr),
        .push_i      (skid_push),
        .push_data_i (resp_entry),
        .pop_i       (skid_pop),
        .valid_o     (skid_v),
        .data_o      (skid_data)
    );

    assign id_valid = ifid_v_q;
    assign instr    = ifid_q.instr;
    assign opcode   = opcode_of(ifid_q.instr);
    assign pc_plus  = ifid_q.pc_plus;

`ifdef IF_PERF_CNT_EN
    logic        ifid_load;
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    assign ifid_load = ifid_open && (skid_v || resp_live) && !redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (ifid_load) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (ifid_v_q && stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
